// File: rtl/scan_frame_sequencer.sv
// scan_frame_sequencer: frame-level load / iterate / unload controller for the iterative SCAN polar decoder core
// Ports: llr_valid/llr_in/llr_ready accept one frame of N LLRs, forwarded as llr_to_core/llr_to_core_vld;
//        channel, program_counter, iter_idx and last_iter drive the core schedule for iter_cfg iterations;
//        hard_valid/hard_bits carry leaf bit pairs from the core; decoded_bits/out_valid/out_ready/frame_err
//        present the decoded frame.
module scan_frame_sequencer #(
  parameter int N = 1024,
  parameter int Q = 6,
  parameter int MAX_ITER = 4,
  parameter int SCHED_LEN = 1200,
  parameter int ITER_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              llr_valid,
  input  logic [Q-1:0]      llr_in,
  output logic              llr_ready,
  input  logic [ITER_W-1:0] iter_cfg,
  output logic              channel,
  output logic [Q-1:0]      llr_to_core,
  output logic              llr_to_core_vld,
  output logic [15:0]       program_counter,
  output logic [ITER_W-1:0] iter_idx,
  output logic              last_iter,
  input  logic              hard_valid,
  input  logic [1:0]        hard_bits,
  output logic [N-1:0]      decoded_bits,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err
);
  localparam int CW = $clog2(N + 1);
  localparam logic [15:0] PC_START = 16'hFFFE;
  localparam logic [15:0] PC_LAST = 16'(SCHED_LEN - 1);
  typedef enum logic [1:0] {IDLE, LOAD, DECODE, OUT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] load_cnt, bit_cnt, bit_cnt_nx;
  logic [ITER_W-1:0] iter_lim, iter_lim_cfg;
  logic accept, iter_end, frame_end, cap, cap_in, cap_drop;
  assign llr_ready = state == IDLE || state == LOAD;
  assign accept = llr_ready && llr_valid;
  assign channel = state == DECODE;
  assign out_valid = state == OUT;
  assign last_iter = channel && iter_idx == iter_lim - ITER_W'(1);
  assign iter_end = channel && program_counter == PC_LAST;
  assign frame_end = iter_end && last_iter;
  assign iter_lim_cfg = iter_cfg == '0 ? ITER_W'(1) :
                        iter_cfg > ITER_W'(MAX_ITER) ? ITER_W'(MAX_ITER) : iter_cfg;
  // Leaf pairs only count on the final iteration; overflow beyond N is dropped and flagged.
  assign cap = last_iter && hard_valid;
  assign cap_in = cap && bit_cnt < CW'(N);
  assign cap_drop = cap && !cap_in;
  assign bit_cnt_nx = cap_in ? bit_cnt + CW'(2) : bit_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? ((N == 1) ? DECODE : LOAD) : IDLE;
      LOAD:    state_nx = accept && load_cnt == CW'(N - 1) ? DECODE : LOAD;
      DECODE:  state_nx = frame_end ? OUT : DECODE;
      OUT:     state_nx = out_ready ? IDLE : OUT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      load_cnt <= '0;
      bit_cnt <= '0;
      iter_lim <= '0;
      iter_idx <= '0;
      program_counter <= PC_START;
      llr_to_core <= '0;
      llr_to_core_vld <= 1'b0;
      decoded_bits <= '0;
      frame_err <= 1'b0;
    end else begin
      llr_to_core_vld <= accept;
      if (accept) llr_to_core <= llr_in;
      if (state == IDLE && accept) begin
        iter_lim <= iter_lim_cfg;
        load_cnt <= CW'(1);
        frame_err <= 1'b0;
      end else if (state == LOAD && accept) begin
        load_cnt <= load_cnt + CW'(1);
      end
      if (channel) program_counter <= iter_end ? PC_START : program_counter + 16'd1;
      if (iter_end && !last_iter) iter_idx <= iter_idx + ITER_W'(1);
      for (int i = 0; i < N; i += 2)
        if (cap_in && bit_cnt == CW'(i)) decoded_bits[i +: 2] <= hard_bits;
      bit_cnt <= bit_cnt_nx;
      // The completion check sees this cycle's capture, so a pair on the very last step still counts.
      if (cap_drop || (frame_end && bit_cnt_nx != CW'(N))) frame_err <= 1'b1;
      if (out_valid && out_ready) begin
        load_cnt <= '0;
        bit_cnt <= '0;
        iter_idx <= '0;
        program_counter <= PC_START;
      end
    end
endmodule

// File: tb/tb_scan_frame_sequencer.sv
// tb_scan_frame_sequencer: directed frames with a per-cycle reference model of scan_frame_sequencer
module tb_scan_frame_sequencer;
  localparam int N = 8, Q = 6, MAX_ITER = 4, SCHED_LEN = 10, ITER_W = 3;
  localparam int SL2 = SCHED_LEN + 2;
  logic clk = 1'b0, rst = 1'b1, llr_valid = 1'b0, hard_valid = 1'b0, out_ready = 1'b0;
  logic [Q-1:0] llr_in = '0;
  logic [ITER_W-1:0] iter_cfg = '0;
  logic [1:0] hard_bits = '0;
  logic llr_ready, channel, llr_to_core_vld, last_iter, out_valid, frame_err;
  logic [Q-1:0] llr_to_core;
  logic [15:0] program_counter;
  logic [ITER_W-1:0] iter_idx;
  logic [N-1:0] decoded_bits;
  int n_chk = 0, n_fail = 0;
  scan_frame_sequencer #(.N(N), .Q(Q), .MAX_ITER(MAX_ITER), .SCHED_LEN(SCHED_LEN), .ITER_W(ITER_W)) dut (
    .clk(clk), .rst(rst), .llr_valid(llr_valid), .llr_in(llr_in), .llr_ready(llr_ready),
    .iter_cfg(iter_cfg), .channel(channel), .llr_to_core(llr_to_core), .llr_to_core_vld(llr_to_core_vld),
    .program_counter(program_counter), .iter_idx(iter_idx), .last_iter(last_iter),
    .hard_valid(hard_valid), .hard_bits(hard_bits), .decoded_bits(decoded_bits),
    .out_valid(out_valid), .out_ready(out_ready), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: frame progress as counts (LLRs taken, decode cycles elapsed), checked every negedge.
  // Inputs change #1 after posedge, so at negedge they are what the next posedge will sample.
  logic [N-1:0] m_bits;
  logic [Q-1:0] m_llr;
  logic m_err, m_vld, dec, outp, acc;
  logic [15:0] e_pc;
  int m_loaded, m_k, m_lim, m_cnt;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_bits = '0; m_llr = '0; m_err = 1'b0; m_vld = 1'b0;
        m_loaded = 0; m_k = 0; m_lim = 1; m_cnt = 0;
      end
      dec = m_loaded == N && m_k < m_lim * SL2;
      outp = m_loaded == N && !dec;
      e_pc = dec ? 16'(m_k % SL2) - 16'd2 : 16'hFFFE;
      chk("llr_ready", llr_ready, m_loaded < N);
      chk("channel", channel, dec);
      chk("program_counter", program_counter, e_pc);
      chk("iter_idx", iter_idx, dec ? m_k / SL2 : outp ? m_lim - 1 : 0);
      chk("last_iter", last_iter, dec && m_k / SL2 == m_lim - 1);
      chk("llr_to_core_vld", llr_to_core_vld, m_vld);
      chk("llr_to_core", llr_to_core, m_llr);
      chk("decoded_bits", decoded_bits, m_bits);
      chk("out_valid", out_valid, outp);
      chk("frame_err", frame_err, m_err);
      if (!rst) begin
        acc = llr_valid && m_loaded < N;
        m_vld = acc;
        if (acc) begin
          m_llr = llr_in;
          if (m_loaded == 0) begin
            m_lim = iter_cfg == 0 ? 1 : iter_cfg > MAX_ITER ? MAX_ITER : int'(iter_cfg);
            m_err = 1'b0;
            m_cnt = 0;
          end
          m_loaded++;
          m_k = 0;
        end else if (dec) begin
          if (hard_valid && m_k / SL2 == m_lim - 1) begin
            if (m_cnt < N) begin
              m_bits[m_cnt] = hard_bits[0];
              m_bits[m_cnt + 1] = hard_bits[1];
              m_cnt += 2;
            end else m_err = 1'b1;
          end
          m_k++;
          if (m_k == m_lim * SL2 && m_cnt != N) m_err = 1'b1;
        end else if (outp && out_ready) begin
          m_loaded = 0;
          m_k = 0;
        end
      end
    end
  end
  task automatic send_frame(input int cfg, input int cnt, input bit stalls, input int base);
    int w;
    for (int i = 0; i < cnt; i++) begin
      if (stalls && i % 3 == 1) begin
        llr_valid = 1'b0;
        @(posedge clk); #1;
      end
      llr_valid = 1'b1;
      llr_in = Q'(base + i);
      iter_cfg = i == 0 ? ITER_W'(cfg) : 3'd6;
      w = 0;
      while (!llr_ready && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      chk("llr_ready_wait", llr_ready, 1);
      @(posedge clk); #1;
    end
    llr_valid = 1'b0;
  endtask
  // Drives leaf pulses at odd steps of the final iteration (pair j at step 2j+1); early adds
  // pulses in iteration 0 that must be ignored. Returns decode length and pc==9 sightings.
  task automatic run_decode(input int lim, input int np, input logic [9:0] pairs, input bit early,
                            output int len, output int wraps);
    int pos;
    len = 0;
    wraps = 0;
    while (channel === 1'b1 && len < 200) begin
      pos = len % SL2;
      hard_valid = 1'b0;
      hard_bits = 2'b00;
      if (early && len < SL2 && pos % 3 == 0) begin
        hard_valid = 1'b1;
        hard_bits = 2'b10;
      end
      if (len / SL2 == lim - 1 && pos % 2 == 1 && pos / 2 < np) begin
        hard_valid = 1'b1;
        hard_bits = pairs[2 * (pos / 2) +: 2];
      end
      if (program_counter == 16'd9) wraps++;
      @(posedge clk); #1;
      len++;
    end
    hard_valid = 1'b0;
  endtask
  task automatic handshake(input int hold, input logic [N-1:0] exp_bits);
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_bits", decoded_bits, exp_bits);
      chk("hold_llr_ready", llr_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_llr_ready", llr_ready, 1);
    chk("idle_out_valid", out_valid, 0);
  endtask
  initial begin
    int len, wr, c;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_llr_ready", llr_ready, 1);
    chk("rst_pc", program_counter, 16'hFFFE);
    chk("rst_channel", channel, 0);
    chk("rst_bits", decoded_bits, 0);
    chk("rst_out_valid", out_valid, 0);
    // 1: reset in the middle of a load
    send_frame(2, 5, 0, 10);
    chk("mid_load_vld", llr_to_core_vld, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_llr_ready", llr_ready, 1);
    chk("mid_rst_channel", channel, 0);
    chk("mid_rst_pc", program_counter, 16'hFFFE);
    chk("mid_rst_vld", llr_to_core_vld, 0);
    chk("mid_rst_llr", llr_to_core, 0);
    @(posedge clk); #1 rst = 1'b0;
    // 2 + 5: two iterations, stalled load, long output stall
    send_frame(2, N, 1, 20);
    run_decode(2, 4, 10'b00_0011_1001, 0, len, wr);
    chk("t2_len", len, 24);
    chk("t2_wraps", wr, 2);
    chk("t2_bits", decoded_bits, 8'b0011_1001);
    chk("t2_err", frame_err, 0);
    handshake(20, 8'b0011_1001);
    // 3: iteration count clamping; non-final pulses ignored
    send_frame(0, N, 0, 30);
    run_decode(1, 4, 10'b00_1100_1111, 0, len, wr);
    chk("t3a_len", len, 12);
    chk("t3a_bits", decoded_bits, 8'b1100_1111);
    chk("t3a_err", frame_err, 0);
    handshake(0, 8'b1100_1111);
    send_frame(7, N, 0, 35);
    run_decode(4, 4, 10'b00_0101_0101, 1, len, wr);
    chk("t3b_len", len, 48);
    chk("t3b_bits", decoded_bits, 8'b0101_0101);
    chk("t3b_err", frame_err, 0);
    handshake(0, 8'b0101_0101);
    // 4: too many and too few leaf pairs
    send_frame(1, N, 0, 40);
    run_decode(1, 5, 10'b11_1010_1010, 0, len, wr);
    chk("t4a_bits", decoded_bits, 8'b1010_1010);
    chk("t4a_err", frame_err, 1);
    handshake(3, 8'b1010_1010);
    send_frame(1, N, 0, 45);
    run_decode(1, 3, 10'b00_0001_0101, 0, len, wr);
    chk("t4b_bits", decoded_bits, 8'b1001_0101);
    chk("t4b_err", frame_err, 1);
    handshake(0, 8'b1001_0101);
    // 6: back-to-back frames with llr_valid and out_ready held high
    send_frame(1, N, 0, 50);
    llr_valid = 1'b1;
    llr_in = 6'h2A;
    iter_cfg = 3'd2;
    out_ready = 1'b1;
    run_decode(1, 4, 10'b00_1111_1111, 0, len, wr);
    chk("t6a_bits", decoded_bits, 8'b1111_1111);
    chk("t6a_err", frame_err, 0);
    c = 0;
    while (llr_to_core_vld !== 1'b1 && c < 10) begin
      @(posedge clk); #1;
      c++;
    end
    chk("t6_first_accept", c, 2);
    chk("t6_first_llr", llr_to_core, 6'h2A);
    send_frame(2, N - 1, 0, 60);
    run_decode(2, 4, 10'b00_0000_0000, 0, len, wr);
    chk("t6b_len", len, 24);
    chk("t6b_bits", decoded_bits, 8'b0000_0000);
    chk("t6b_err", frame_err, 0);
    handshake(0, 8'b0000_0000);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/scan_frame_sequencer.md
Name: scan_frame_sequencer

Overview:
- Frame-level controller for the iterative SCAN polar decoder core; parametrised successor to the single-pass decode top.
- Accepts one frame of N channel LLRs over a valid/ready stream and runs a runtime-selectable number of SCAN iterations.
- Drives the core's `channel` and program-counter inputs, captures leaf hard-bit pairs on the final iteration, and presents the N-bit result over a valid/ready output handshake.

Parameters:
- N, 1024, code length in bits; even, ≥ 4.
- Q, 6, LLR quantisation width.
- MAX_ITER, 4, maximum SCAN iterations per frame; ≥ 1.
- SCHED_LEN, 1200, schedule steps per iteration. Program counter runs -2 .. SCHED_LEN-1.
- ITER_W, 3, width of iter_cfg; must satisfy 2^ITER_W > MAX_ITER.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous, active-high reset.
- llr_valid, in, 1: input LLR valid.
- llr_in, in, Q: input LLR sample.
- llr_ready, out, 1: sequencer can accept an LLR.
- iter_cfg, in, ITER_W: requested iteration count.
- channel, out, 1: 1 = core decoding, 0 = core reading LLRs.
- llr_to_core, out, Q: registered copy of the accepted LLR.
- llr_to_core_vld, out, 1: llr_to_core valid for one cycle.
- program_counter, out, 16: core schedule step.
- iter_idx, out, ITER_W: current iteration, 0-based.
- last_iter, out, 1: current iteration is the final one.
- hard_valid, in, 1: core leaf (BOTTOM) result valid this cycle.
- hard_bits, in, 2: leaf bit pair; bit 0 is the lower index.
- decoded_bits, out, N: decoded frame.
- out_valid, out, 1: decoded_bits valid.
- out_ready, in, 1: consumer accepts the frame.
- frame_err, out, 1: bit-count mismatch for the presented frame.

Behaviour:
- Reset (async, any state): state = IDLE and all counters are 0. Outputs take these values:
  - channel = 0, program_counter = 16'hFFFE.
  - llr_ready = 1, llr_to_core_vld = 0, llr_to_core = 0.
  - iter_idx = 0, last_iter = 0.
  - decoded_bits = 0, out_valid = 0, frame_err = 0.
- States are IDLE, LOAD, DECODE and OUT.
- IDLE:
  - llr_ready = 1.
  - On llr_valid, latch the iteration limit: iter_lim = iter_cfg, with 0 → 1 and values > MAX_ITER → MAX_ITER.
  - Accept the sample, load_cnt = 1, go to LOAD. If N == 1, go straight to DECODE.
- LOAD:
  - llr_ready = 1.
  - Each accepted sample is registered to llr_to_core, with llr_to_core_vld = 1 on the next cycle.
  - Accepting the N-th sample (load_cnt == N-1) moves to DECODE on the next edge.
  - Stalls (llr_valid = 0) hold load_cnt. iter_cfg is ignored in this state.
- DECODE:
  - llr_ready = 0 and channel = 1.
  - The first DECODE cycle has program_counter = -2, incrementing by 1 per cycle.
  - When program_counter == SCHED_LEN-1:
    - if iter_idx == iter_lim-1, go to OUT;
    - otherwise iter_idx += 1 and program_counter reloads to -2 on the next cycle.
  - channel stays 1 across iteration boundaries.
  - One iteration takes SCHED_LEN+2 cycles.
  - last_iter = (iter_idx == iter_lim-1) while in DECODE.
- Bit capture:
  - Captures only when last_iter = 1 and hard_valid = 1.
  - decoded_bits[bit_cnt] = hard_bits[0] and decoded_bits[bit_cnt+1] = hard_bits[1]; then bit_cnt += 2.
  - hard_valid in earlier iterations is ignored.
  - Captures with bit_cnt ≥ N are dropped and set frame_err.
  - On leaving DECODE, bit_cnt != N also sets frame_err.
- OUT:
  - channel = 0, program_counter = -2, out_valid = 1.
  - decoded_bits and frame_err hold stable while out_valid = 1 and out_ready = 0.
  - On out_valid & out_ready, go to IDLE on the next cycle and clear out_valid and all counters. decoded_bits holds its value; frame_err clears at the next frame's first LLR accept.
  - llr_ready = 0 in OUT, so there is no overlap with the next frame.
- Latency: the N-th LLR accept at edge t gives the first DECODE cycle at t+1. out_valid rises at t+1+iter_lim·(SCHED_LEN+2).
- hard_valid while not in DECODE is ignored.
- A reset asserted mid-frame discards the frame with no output.

Test Plan (N=8, SCHED_LEN=10, MAX_ITER=4, ITER_W=3):
1. Reset mid-LOAD after 5 LLRs → llr_ready = 1, channel = 0, program_counter = 16'hFFFE immediately. The next 8 LLRs form a full frame.
2. iter_cfg = 2; stream 8 LLRs with stalls. In the last iteration, pulse hard_valid 4× with pairs 01, 10, 11, 00.
   - DECODE lasts 24 cycles and program_counter wraps -2 → 9 twice.
   - Expect decoded_bits = 8'b0011_1001, frame_err = 0.
3. iter_cfg = 0 → exactly 1 iteration (12 cycles). iter_cfg = 7 → 4 iterations (48 cycles). hard_valid in non-final iterations leaves decoded_bits unchanged.
4. In the final iteration, give 5 hard_valid pulses → first 4 captured, frame_err = 1. Give 3 pulses → frame_err = 1.
5. Hold out_ready = 0 for 20 cycles → out_valid and decoded_bits stable, llr_ready = 0. Raise out_ready → IDLE on the next cycle and a new frame loads.
6. Back-to-back frames with continuous llr_valid and out_ready = 1 → the second frame's first LLR is accepted 1 cycle after the OUT handshake.
